// File: rtl/dac_out_pkg.sv
// rtl/dac_out_pkg.sv - shared types and sample conversion helpers for the DAC output formatter
package dac_out_pkg;

  typedef enum logic {IDLE, RUN} seq_state_t;

  // Where the channels of the frame currently being sequenced come from
  typedef enum logic [1:0] {SRC_FIFO, SRC_MID, SRC_RAMP} src_t;

  // DAC code representing zero signal
  function automatic logic [31:0] midscale(input int dacw, input int ob);
    return (ob != 0) ? (32'd1 << (dacw - 1)) : 32'd0;
  endfunction

  // Round half-up, saturate to the input range, keep the top dacw bits, optionally offset-binary
  function automatic logic [31:0] sat_round(input logic signed [31:0] x, input int dw,
                                            input int dacw, input int ob);
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] q;
    logic [63:0]        mask;
    logic [31:0]        r;
    y = 64'(x);
    if (dw > dacw) y = y + (64'sd1 <<< (dw - dacw - 1));
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (y > hi) y = hi;
    else if (y < lo) y = lo;
    q    = y >>> (dw - dacw);
    mask = (64'd1 << dacw) - 64'd1;
    r    = q[31:0] & mask[31:0];
    if (ob != 0) r[dacw-1] = ~r[dacw-1];
    return r;
  endfunction

endpackage

// File: rtl/dac_out_fifo.sv
// rtl/dac_out_fifo.sv - single-clock frame FIFO with full/empty/level
module dac_out_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Storage array, not reset: contents are only visible through level
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

  // Pointers and occupancy; push and pop in one cycle leave level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rp];
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/dac_out_fmt.sv
// rtl/dac_out_fmt.sv - multi-channel DAC formatter (optional test ramp under DACOUT_RAMP_EN)
module dac_out_fmt
  import dac_out_pkg::*;
#(
  parameter int DW         = 16,
  parameter int DACW       = 14,
  parameter int NCH        = 2,
  parameter int DEPTH      = 8,
  parameter int OFFSET_BIN = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [7:0]                             rate_div,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [NCH*DW-1:0]                      s_data,
  output logic [DACW-1:0]                        dac_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] dac_ch,
  output logic                                   dac_strobe,
  output logic                                   underrun,
  input  logic                                   underrun_clr,
`ifdef DACOUT_RAMP_EN
  input  logic                                   ramp_mode,
`endif
  output logic [$clog2(DEPTH):0]                 fifo_level
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DACW-1:0] MID = DACW'(midscale(DACW, OFFSET_BIN));

  logic [7:0]              cnt;
  logic                    tick;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    slot;
  logic                    ramp;
  logic [NCH*DW-1:0]       head;
  logic [NCH*DW-1:0]       frame;
  seq_state_t              state;
  src_t                    src;
  logic [CW-1:0]           ch;
  logic [CW-1:0]           nxt_ch;
  logic signed [DW-1:0]    sample;
  logic [DACW-1:0]         conv;

`ifdef DACOUT_RAMP_EN
  logic [DACW-1:0]         ramp_cnt;
  logic [DACW-1:0]         ramp_hold;
  assign ramp = ramp_mode;
`else
  assign ramp = 1'b0;
`endif

  // A tick is a slot boundary: either the first slot after IDLE or the one after the last channel
  assign tick    = en && (cnt == 8'd0);
  assign slot    = (state == IDLE) || (ch == CW'(NCH - 1));
  assign s_ready = !full && !ramp;
  assign push    = s_valid && s_ready;
  assign pop     = tick && slot && !empty && !ramp;

  dac_out_fifo #(.W(NCH*DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Pick the sample for the next channel: FIFO head on a new frame, otherwise the held frame
  always_comb begin
    nxt_ch = slot ? '0 : ch + 1'b1;
    sample = slot ? head[DW-1:0] : frame[nxt_ch*DW +: DW];
    conv   = DACW'(sat_round(32'(sample), DW, DACW, OFFSET_BIN));
  end

  // Strobe-period counter; reloads the live rate_div whenever it expires or en is low
  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= rate_div;
    else if (cnt == 8'd0) cnt <= rate_div;
    else                  cnt <= cnt - 8'd1;
  end

  // Channel sequencer and registered DAC outputs; underrun set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_MID;
      ch         <= '0;
      frame      <= '0;
      dac_data   <= MID;
      dac_ch     <= '0;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
`ifdef DACOUT_RAMP_EN
      ramp_cnt   <= '0;
      ramp_hold  <= '0;
`endif
    end else begin
      dac_strobe <= tick;
      if (underrun_clr) underrun <= 1'b0;
      if (tick) begin
        state  <= RUN;
        ch     <= nxt_ch;
        dac_ch <= nxt_ch;
        if (slot) begin
`ifdef DACOUT_RAMP_EN
          if (ramp) begin
            src       <= SRC_RAMP;
            ramp_hold <= ramp_cnt;
            ramp_cnt  <= ramp_cnt + 1'b1;
            dac_data  <= ramp_cnt;
          end else
`endif
          if (!empty) begin
            src      <= SRC_FIFO;
            frame    <= head;
            dac_data <= conv;
          end else begin
            src      <= SRC_MID;
            underrun <= 1'b1;
            dac_data <= MID;
          end
        end else begin
          case (src)
            SRC_FIFO: dac_data <= conv;
`ifdef DACOUT_RAMP_EN
            SRC_RAMP: dac_data <= ramp_hold;
`endif
            default:  dac_data <= MID;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_out_fmt.sv
// tb/tb_dac_out_fmt.sv - self-checking bench for dac_out_fmt with a frame-level reference model
module tb_dac_out_fmt;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam logic [13:0] MID = 14'h2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  rate_div;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [13:0] dac_data;
  logic [0:0]  dac_ch;
  logic        dac_strobe;
  logic        underrun;
  logic        underrun_clr;
  logic [3:0]  fifo_level;
`ifdef DACOUT_RAMP_EN
  logic        ramp_mode = 1'b0;
`endif

  int nvec = 0;
  int nbad = 0;

  logic [31:0] fq[$];
  logic [31:0] mframe;
  int          mch;
  bit          mur_frame;
  bit          mur;

  always #5 clk = ~clk;

  dac_out_fmt dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rate_div     (rate_div),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .dac_data     (dac_data),
    .dac_ch       (dac_ch),
    .dac_strobe   (dac_strobe),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
`ifdef DACOUT_RAMP_EN
    .ramp_mode    (ramp_mode),
`endif
    .fifo_level   (fifo_level)
  );

  // Expected 14-bit offset-binary code: round half-up by 4, clamp, floor-divide, add midscale
  function automatic logic [13:0] ref_code(input logic [15:0] x);
    int v;
    int y;
    int q;
    v = $signed(x);
    y = v + 2;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    q = (y >= 0) ? (y / 4) : -((-y + 3) / 4);
    return 14'(q + 8192);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write one frame (s_valid left high for back-to-back use); model accepts only if not full
  task automatic wr(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    if (fq.size() < DEPTH) fq.push_back(d);
    chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
    chk("s_ready", 32'(s_ready), 32'(fq.size() < DEPTH));
  endtask

  // One strobe period of R+1 cycles. clr_mode 1: clear on the tick edge, 2: clear on the first gap edge
  task automatic strobe(input int r, input int clr_mode);
    logic [13:0] exp_d;
    for (int i = 0; i < r; i++) begin
      underrun_clr = (clr_mode == 2 && i == 0);
      step();
      underrun_clr = 1'b0;
      if (clr_mode == 2 && i == 0) begin
        mur = 1'b0;
        chk("underrun_gap_clear", 32'(underrun), 32'(mur));
      end
      chk("gap_strobe", 32'(dac_strobe), 32'd0);
    end
    underrun_clr = (clr_mode == 1);
    if (mch == 0) begin
      if (fq.size() > 0) begin
        mframe    = fq.pop_front();
        mur_frame = 1'b0;
      end else begin
        mur_frame = 1'b1;
      end
    end
    exp_d = mur_frame ? MID : ref_code(mframe[mch*16 +: 16]);
    if (clr_mode == 1) mur = 1'b0;
    if (mch == 0 && mur_frame) mur = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("strobe", 32'(dac_strobe), 32'd1);
    chk("dac_data", 32'(dac_data), 32'(exp_d));
    chk("dac_ch", 32'(dac_ch), 32'(mch));
    chk("underrun", 32'(underrun), 32'(mur));
    mch = (mch + 1) % NCH;
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    rate_div = 8'd3; s_data = '0;
    mch = 0; mur = 1'b0; mur_frame = 1'b1; mframe = '0;
    step(); step();
    chk("rst_dac_data", 32'(dac_data), 32'(MID));
    chk("rst_strobe", 32'(dac_strobe), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ch", 32'(dac_ch), 32'd0);
    rst = 1'b0;
    step();

    // Directed conversion corners: {Q, I}
    wr({16'h7FFF, 16'h0000});
    wr({16'h0001, 16'h8000});
    wr({16'hFFFE, 16'h0002});
    s_valid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 8; k++) strobe(3, 0);
    en = 1'b0;
    step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    mur = 1'b0;
    chk("underrun_idle_clear", 32'(underrun), 32'(mur));

    // Fill past full with en low, then drain at one strobe per cycle
    rate_div = 8'd0;
    for (int k = 0; k < 9; k++) wr($urandom);
    s_valid = 1'b0;
    en = 1'b1;
    strobe(0, 0);
    chk("s_ready_after_pop", 32'(s_ready), 32'd1);
    chk("level_after_pop", 32'(fifo_level), 32'd7);
    for (int k = 0; k < 17; k++) strobe(0, 0);
    en = 1'b0;

    // Underrun clear behaviour on and between ticks
    rate_div = 8'd2;
    step();
    en = 1'b1;
    strobe(2, 2);
    strobe(2, 2);
    strobe(2, 1);
    strobe(2, 0);
    en = 1'b0;
    step();

    // Randomized frames and strobe rates
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 8);
      r = $urandom_range(0, 4);
      rate_div = 8'(r);
      step();
      for (int k = 0; k < n; k++) wr($urandom);
      s_valid = 1'b0;
      en = 1'b1;
      for (int k = 0; k < (n + 1) * NCH; k++) strobe(r, 0);
      en = 1'b0;
      step();
    end

    // Reset between the ch0 and ch1 strobes with frames queued
    rate_div = 8'd3;
    step();
    for (int k = 0; k < 3; k++) wr($urandom);
    s_valid = 1'b0;
    en = 1'b1;
    strobe(3, 0);
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
    fq.delete();
    mch = 0;
    mur = 1'b0;
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_dac_data", 32'(dac_data), 32'(MID));
    chk("midrst_strobe", 32'(dac_strobe), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_underrun", 32'(underrun), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midrst_no_strobe", 32'(dac_strobe), 32'd0);
    end
    en = 1'b1;
    strobe(3, 0);
    strobe(3, 0);
    en = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
